layer1_column_drain: RTL

- Sequencer and reader on the result side of the Layer 1 ten-lane MAC column array.
- Controls the array's accumulate-clear line and times one K-term accumulation window.
- Snapshots the LANES x W column result into a shadow register.
- Drains the snapshot downstream one W-bit word per valid/ready handshake, lane 0 first.

---
 rtl/layer1_column_drain.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/layer1_column_drain.sv
// Layer 1 column drain: sequences one K-term accumulate window on the MAC column,
// snapshots the lanes, then drains them lane 0 first over valid/ready. Optional macro: LAYER1_DRAIN_RELU_EN.
module layer1_column_drain #(
   parameter int LANES   = 10,
   parameter int W       = 16,
   parameter int K       = 9,
   parameter int MAC_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [LANES*W-1:0] column,
   output logic               mac_clear,
   output logic               pix_req,
   output logic [W-1:0]       out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   localparam int ACC_W  = $clog2(K + MAC_LAT + 1);
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [ACC_W-1:0]  K_C       = ACC_W'(K);
   localparam logic [ACC_W-1:0]  ACC_LAST  = ACC_W'(K + MAC_LAT - 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   // Handshake: a word transfers on any rising edge where out_valid && out_ready;
   // out_data/out_last are frozen while out_valid is high and out_ready is low.
   state_t              r_state, w_next_state;
   logic [ACC_W-1:0]    r_acc_cnt;
   logic [LANE_W-1:0]   r_lane_idx;
   logic                r_pending;
   logic [W-1:0]        r_shadow [LANES];
   logic [W-1:0]        r_out_data;
   logic                r_out_valid;
   logic                r_out_last;
   logic                w_mac_clear;
   logic                w_pix_req;
   logic                w_hs;
   logic                w_last_lane;
   logic                w_final_hs;
   logic [LANE_W-1:0]   w_lane_nxt;

   function automatic logic [W-1:0] f_lane(input logic [W-1:0] v);
`ifdef LAYER1_DRAIN_RELU_EN
      return v[W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign w_hs        = r_out_valid && out_ready;
   assign w_last_lane = (r_lane_idx == LAST_LANE);
   assign w_final_hs  = (r_state == S_DRAIN) && w_hs && w_last_lane;
   assign w_lane_nxt  = r_lane_idx + LANE_W'(1);

   always_comb begin
      w_next_state = r_state;
      w_mac_clear  = 1'b1;
      w_pix_req    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next_state = S_ACCUM;
         end
         S_ACCUM: begin
            w_mac_clear = 1'b0;
            w_pix_req   = (r_acc_cnt < K_C);
            if (r_acc_cnt == ACC_LAST) w_next_state = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            // A start arriving with the final handshake counts as pending.
            if (w_final_hs) w_next_state = (r_pending || start) ? S_ACCUM : S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_acc_cnt   <= '0;
         r_lane_idx  <= '0;
         r_pending   <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         for (int i = 0; i < LANES; i++) r_shadow[i] <= '0;
      end else begin
         r_state   <= w_next_state;
         r_acc_cnt <= (r_state == S_ACCUM) ? r_acc_cnt + ACC_W'(1) : '0;

         if (r_state == S_DRAIN) begin
            if (w_final_hs)   r_pending <= 1'b0;
            else if (start)   r_pending <= 1'b1;
         end else begin
            r_pending <= 1'b0;
         end

         if (r_state == S_CAPTURE) begin
            for (int i = 0; i < LANES; i++) r_shadow[i] <= f_lane(column[i*W +: W]);
            // Lane 0 goes straight to the output so the first word is valid next cycle.
            r_lane_idx  <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= f_lane(column[W-1:0]);
            r_out_last  <= (LAST_LANE == '0);
         end else if (r_state == S_DRAIN && w_hs) begin
            if (w_last_lane) begin
               r_lane_idx  <= '0;
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
            end else begin
               r_lane_idx  <= w_lane_nxt;
               r_out_data  <= r_shadow[w_lane_nxt];
               r_out_last  <= (w_lane_nxt == LAST_LANE);
            end
         end
      end
   end

   assign mac_clear = w_mac_clear;
   assign pix_req   = w_pix_req;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign busy      = (r_state != S_IDLE);
   assign dbg_state = r_state;

endmodule
